// File: rtl/gbc_mem_pkg.sv
// Shared memory-subsystem definitions: requester-ID encoding, address/data
// widths and the default starvation limit used by the BRAM arbiter.
package gbc_mem_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 8;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/bram_arb_pick.sv
// Winner selection for the two-requester BRAM arbiter.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   cpu_req, dma_req   : level requests
//   cpu_win, dma_win   : combinational winner (at most one high)
// Build option: BRAM_ARB_RR_EN selects round-robin tie-breaking with a
// 1-bit last-winner pointer; otherwise fixed CPU priority with a DMA
// starvation counter.
module bram_arb_pick
  import gbc_mem_pkg::*;
#(
  parameter int P_STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic dma_req,
  output logic cpu_win,
  output logic dma_win
);

`ifdef BRAM_ARB_RR_EN

  req_id_e last_q, last_d;

  always_comb begin
    last_d  = last_q;
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (cpu_req && dma_req) begin
      // The requester that did not win last time takes the tie.
      if (last_q == REQ_DMA) cpu_win = 1'b1;
      else                   dma_win = 1'b1;
    end else begin
      cpu_win = cpu_req;
      dma_win = dma_req;
    end
    if (cpu_win)      last_d = REQ_CPU;
    else if (dma_win) last_d = REQ_DMA;
  end

  // Reset to DMA so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_DMA;
    else        last_q <= last_d;
  end

`else

  localparam int CNT_W = $clog2(P_STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starved;

  // Counter never passes P_STARVE_MAX: reaching it forces the next DMA win.
  assign starved = (cnt_q == CNT_W'(P_STARVE_MAX));

  always_comb begin
    cnt_d   = cnt_q;
    dma_win = dma_req && (!cpu_req || starved);
    cpu_win = cpu_req && !dma_win;
    if (!dma_req || dma_win) cnt_d = '0;
    else                     cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

`endif

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a single-port BRAM with one-cycle
// read latency. Grant in cycle N, BRAM access in N+1, read data returned to
// the requester in N+2.
// Ports:
//   I_CLK, I_RESET_L                  : clock, async active-low reset
//   I_{CPU,DMA}_REQ/_WE/_ADDR/_WDATA  : requester inputs
//   O_{CPU,DMA}_GNT                   : one-cycle acceptance pulse
//   O_{CPU,DMA}_RVALID/_RDATA         : read return
//   O_BRAM_EN/_WE/_ADDR/_DIN, I_BRAM_DOUT : BRAM port
// Build option: BRAM_ARB_RR_EN (round-robin ties; default fixed CPU priority
// with DMA starvation counter), implemented in bram_arb_pick.
module bram_arbiter
  import gbc_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] P_OFFSET_MASK = 16'h00FF,
  parameter int                P_STARVE_MAX  = STARVE_MAX_DEF
) (
  input  logic              I_CLK,
  input  logic              I_RESET_L,
  input  logic              I_CPU_REQ,
  input  logic              I_DMA_REQ,
  input  logic              I_CPU_WE,
  input  logic              I_DMA_WE,
  input  logic [ADDR_W-1:0] I_CPU_ADDR,
  input  logic [ADDR_W-1:0] I_DMA_ADDR,
  input  logic [DATA_W-1:0] I_CPU_WDATA,
  input  logic [DATA_W-1:0] I_DMA_WDATA,
  output logic              O_CPU_GNT,
  output logic              O_DMA_GNT,
  output logic              O_CPU_RVALID,
  output logic              O_DMA_RVALID,
  output logic [DATA_W-1:0] O_CPU_RDATA,
  output logic [DATA_W-1:0] O_DMA_RDATA,
  output logic              O_BRAM_EN,
  output logic              O_BRAM_WE,
  output logic [ADDR_W-1:0] O_BRAM_ADDR,
  output logic [DATA_W-1:0] O_BRAM_DIN,
  input  logic [DATA_W-1:0] I_BRAM_DOUT
);

  logic cpu_win, dma_win;

  bram_arb_pick #(.P_STARVE_MAX(P_STARVE_MAX)) u_pick (
    .clk     (I_CLK),
    .rst_n   (I_RESET_L),
    .cpu_req (I_CPU_REQ),
    .dma_req (I_DMA_REQ),
    .cpu_win (cpu_win),
    .dma_win (dma_win)
  );

  // Grants are combinational; gate them so nothing is accepted during reset.
  assign O_CPU_GNT = cpu_win & I_RESET_L;
  assign O_DMA_GNT = dma_win & I_RESET_L;

  logic              en_q, en_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  // Stage-1 tag: a read is being accessed in the BRAM this cycle.
  logic              tag_vld_q, tag_vld_d;
  req_id_e           tag_id_q, tag_id_d;
  // Stage-2: registered read return.
  logic              cpu_rv_q, cpu_rv_d, dma_rv_q, dma_rv_d;
  logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d, dma_rd_q, dma_rd_d;

  always_comb begin
    en_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    tag_vld_d = 1'b0;
    tag_id_d  = tag_id_q;
    if (O_CPU_GNT) begin
      en_d      = 1'b1;
      we_d      = I_CPU_WE;
      addr_d    = I_CPU_ADDR & P_OFFSET_MASK;
      din_d     = I_CPU_WDATA;
      tag_vld_d = ~I_CPU_WE;
      tag_id_d  = REQ_CPU;
    end else if (O_DMA_GNT) begin
      en_d      = 1'b1;
      we_d      = I_DMA_WE;
      addr_d    = I_DMA_ADDR & P_OFFSET_MASK;
      din_d     = I_DMA_WDATA;
      tag_vld_d = ~I_DMA_WE;
      tag_id_d  = REQ_DMA;
    end

    cpu_rv_d = tag_vld_q && (tag_id_q == REQ_CPU);
    dma_rv_d = tag_vld_q && (tag_id_q == REQ_DMA);
    cpu_rd_d = cpu_rv_d ? I_BRAM_DOUT : cpu_rd_q;
    dma_rd_d = dma_rv_d ? I_BRAM_DOUT : dma_rd_q;
  end

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      tag_vld_q <= 1'b0;
      tag_id_q  <= REQ_CPU;
      cpu_rv_q  <= 1'b0;
      dma_rv_q  <= 1'b0;
      cpu_rd_q  <= '0;
      dma_rd_q  <= '0;
    end else begin
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      cpu_rv_q  <= cpu_rv_d;
      dma_rv_q  <= dma_rv_d;
      cpu_rd_q  <= cpu_rd_d;
      dma_rd_q  <= dma_rd_d;
    end
  end

  assign O_BRAM_EN    = en_q;
  assign O_BRAM_WE    = we_q;
  assign O_BRAM_ADDR  = addr_q;
  assign O_BRAM_DIN   = din_q;
  assign O_CPU_RVALID = cpu_rv_q;
  assign O_DMA_RVALID = dma_rv_q;
  assign O_CPU_RDATA  = cpu_rd_q;
  assign O_DMA_RDATA  = dma_rd_q;

endmodule

// File: tb/tb_bram_arbiter.sv
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        cpu_req, dma_req, cpu_we, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic        bram_en, bram_we;
  logic [15:0] bram_addr;
  logic [7:0]  bram_din, bram_dout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bram_arbiter dut (
    .I_CLK(clk), .I_RESET_L(rst_l),
    .I_CPU_REQ(cpu_req), .I_DMA_REQ(dma_req),
    .I_CPU_WE(cpu_we), .I_DMA_WE(dma_we),
    .I_CPU_ADDR(cpu_addr), .I_DMA_ADDR(dma_addr),
    .I_CPU_WDATA(cpu_wdata), .I_DMA_WDATA(dma_wdata),
    .O_CPU_GNT(cpu_gnt), .O_DMA_GNT(dma_gnt),
    .O_CPU_RVALID(cpu_rvalid), .O_DMA_RVALID(dma_rvalid),
    .O_CPU_RDATA(cpu_rdata), .O_DMA_RDATA(dma_rdata),
    .O_BRAM_EN(bram_en), .O_BRAM_WE(bram_we),
    .O_BRAM_ADDR(bram_addr), .O_BRAM_DIN(bram_din),
    .I_BRAM_DOUT(bram_dout)
  );

  typedef struct {
    logic        cr, cw; logic [15:0] ca; logic [7:0] cd;
    logic        dr, dw; logic [15:0] da; logic [7:0] dd;
    logic [7:0]  dout;
    logic        e_cg, e_dg, e_en, e_we;
    logic [15:0] e_addr; logic [7:0] e_din;
    logic        e_cv; logic [7:0] e_crd;
    logic        e_dv; logic [7:0] e_drd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [7:0] dd,
                       input logic [7:0] dout);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    bram_dout = dout;
  endtask

  task automatic idle(input logic [7:0] dout);
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, dout);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_gnt"},    {15'd0, cpu_gnt},    16'h0);
    chk({tag, "_dma_gnt"},    {15'd0, dma_gnt},    16'h0);
    chk({tag, "_bram_en"},    {15'd0, bram_en},    16'h0);
    chk({tag, "_bram_we"},    {15'd0, bram_we},    16'h0);
    chk({tag, "_bram_addr"},  bram_addr,           16'h0);
    chk({tag, "_bram_din"},   {8'd0, bram_din},    16'h0);
    chk({tag, "_cpu_rvalid"}, {15'd0, cpu_rvalid}, 16'h0);
    chk({tag, "_cpu_rdata"},  {8'd0, cpu_rdata},   16'h0);
    chk({tag, "_dma_rvalid"}, {15'd0, dma_rvalid}, 16'h0);
    chk({tag, "_dma_rdata"},  {8'd0, dma_rdata},   16'h0);
  endtask

  initial begin
    logic exp_dma, prev_dma;
    logic both_pat [9];
    logic exp_pat  [9];

    //           cr cw ca      cd     dr dw da      dd     dout  | cg dg en we addr     din    cv crd    dv drd
    vecs[0]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 8'h00};
    vecs[1]  = '{1, 0, 16'h8012, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h00, 1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 8'h00};
    vecs[2]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 8'hA5, 0, 0, 1, 0, 16'h0012, 8'h00, 0, 8'h00, 0, 8'h00};
    vecs[3]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0012, 8'h00, 1, 8'hA5, 0, 8'h00};
    vecs[4]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0012, 8'h00, 0, 8'hA5, 0, 8'h00};
    vecs[5]  = '{1, 0, 16'h0100, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h00, 1, 0, 0, 0, 16'h0012, 8'h00, 0, 8'hA5, 0, 8'h00};
    vecs[6]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0234, 8'h00, 8'h11, 0, 1, 1, 0, 16'h0000, 8'h00, 0, 8'hA5, 0, 8'h00};
    vecs[7]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h22, 0, 0, 1, 0, 16'h0034, 8'h00, 1, 8'h11, 0, 8'h00};
    vecs[8]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0034, 8'h00, 0, 8'h11, 1, 8'h22};
    vecs[9]  = '{0, 0, 16'h0000, 8'h00, 1, 1, 16'hFE9F, 8'h5A, 8'h00, 0, 1, 0, 0, 16'h0034, 8'h00, 0, 8'h11, 0, 8'h22};
    vecs[10] = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h33, 0, 0, 1, 1, 16'h009F, 8'h5A, 0, 8'h11, 0, 8'h22};
    vecs[11] = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 16'h009F, 8'h5A, 0, 8'h11, 0, 8'h22};

    rst_l = 1'b0;
    drive(1'b1, 1'b0, 16'hFFFF, 8'hFF, 1'b1, 1'b0, 16'hFFFF, 8'hFF, 8'hFF);
    #3;
    chk_all_zero("reset_init");
    repeat (2) @(posedge clk);
    #2;
    rst_l = 1'b1;

    // Table: single read, back-to-back reads of both requesters, DMA write.
    foreach (vecs[i]) begin
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd, vecs[i].dout);
      #5;
      chk($sformatf("v%0d_cpu_gnt", i),    {15'd0, cpu_gnt},    {15'd0, vecs[i].e_cg});
      chk($sformatf("v%0d_dma_gnt", i),    {15'd0, dma_gnt},    {15'd0, vecs[i].e_dg});
      chk($sformatf("v%0d_bram_en", i),    {15'd0, bram_en},    {15'd0, vecs[i].e_en});
      chk($sformatf("v%0d_bram_we", i),    {15'd0, bram_we},    {15'd0, vecs[i].e_we});
      chk($sformatf("v%0d_bram_addr", i),  bram_addr,           vecs[i].e_addr);
      chk($sformatf("v%0d_bram_din", i),   {8'd0, bram_din},    {8'd0, vecs[i].e_din});
      chk($sformatf("v%0d_cpu_rvalid", i), {15'd0, cpu_rvalid}, {15'd0, vecs[i].e_cv});
      chk($sformatf("v%0d_cpu_rdata", i),  {8'd0, cpu_rdata},   {8'd0, vecs[i].e_crd});
      chk($sformatf("v%0d_dma_rvalid", i), {15'd0, dma_rvalid}, {15'd0, vecs[i].e_dv});
      chk($sformatf("v%0d_dma_rdata", i),  {8'd0, dma_rdata},   {8'd0, vecs[i].e_drd});
      next_cycle();
    end

    // Both request writes every cycle.
    prev_dma = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drive(1'b1, 1'b1, 16'h1111, 8'hC1, 1'b1, 1'b1, 16'h2222, 8'hD2, 8'h00);
      else        idle(8'h00);
`ifdef BRAM_ARB_RR_EN
      exp_dma = (i % 2) == 1;
`else
      exp_dma = (i % 5) == 4;
`endif
      #5;
      if (i < 10) begin
        chk($sformatf("tie%0d_cpu_gnt", i), {15'd0, cpu_gnt}, {15'd0, ~exp_dma});
        chk($sformatf("tie%0d_dma_gnt", i), {15'd0, dma_gnt}, {15'd0, exp_dma});
      end
      if (i > 0) begin
        chk($sformatf("tie%0d_bram_we", i),   {15'd0, bram_we}, 16'h1);
        chk($sformatf("tie%0d_bram_addr", i), bram_addr, prev_dma ? 16'h0022 : 16'h0011);
        chk($sformatf("tie%0d_bram_din", i),  {8'd0, bram_din}, prev_dma ? 16'h00D2 : 16'h00C1);
        chk($sformatf("tie%0d_no_rvalid", i), {14'd0, cpu_rvalid, dma_rvalid}, 16'h0);
      end
      prev_dma = exp_dma;
      next_cycle();
    end

`ifndef BRAM_ARB_RR_EN
    // Counter clears when DMA drops its request.
    both_pat = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    exp_pat  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 16'h1111, 8'hC1, both_pat[i], 1'b1, 16'h2222, 8'hD2, 8'h00);
      #5;
      chk($sformatf("clr%0d_dma_gnt", i), {15'd0, dma_gnt}, {15'd0, exp_pat[i]});
      chk($sformatf("clr%0d_cpu_gnt", i), {15'd0, cpu_gnt}, {15'd0, ~exp_pat[i]});
      next_cycle();
    end
`endif

    // Lone DMA requester is granted immediately.
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0055, 8'h00, 8'h00);
    #5;
    chk("lone_dma_gnt", {14'd0, cpu_gnt, dma_gnt}, 16'h1);
    next_cycle();

    // Reset pulse right after a CPU read grant discards the read.
    drive(1'b1, 1'b0, 16'h0042, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 8'h00);
    #5;
    chk("rst_pre_cpu_gnt", {15'd0, cpu_gnt}, 16'h1);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0042, 8'h00, 1'b1, 1'b0, 16'h0043, 8'h00, 8'hEE);
    rst_l = 1'b0;
    #1;
    chk_all_zero("in_reset_a");
    next_cycle();
    chk_all_zero("in_reset_b");
    idle(8'hEE);
    rst_l = 1'b1;
    #5;
    chk("post_rst_rvalid0", {14'd0, cpu_rvalid, dma_rvalid}, 16'h0);
    chk("post_rst_en0",     {15'd0, bram_en}, 16'h0);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0077, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 8'h00);
    #5;
    chk("post_rst_rvalid1",   {14'd0, cpu_rvalid, dma_rvalid}, 16'h0);
    chk("post_rst_first_gnt", {15'd0, cpu_gnt}, 16'h1);
    next_cycle();
    idle(8'h9C);
    #5;
    chk("post_rst_en1",   {15'd0, bram_en}, 16'h1);
    chk("post_rst_addr1", bram_addr, 16'h0077);
    next_cycle();
    idle(8'h00);
    #5;
    chk("post_rst_cpu_rvalid", {15'd0, cpu_rvalid}, 16'h1);
    chk("post_rst_cpu_rdata",  {8'd0, cpu_rdata},   16'h009C);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
